nibble_add_seq: RTL and testbench

- Multi-cycle sequencer that adds two WIDTH-bit operands using a single 4-bit ripple-add slice. The slice is reused once per cycle, least-significant nibble first.
- Carry is registered between nibbles.
- Used where a wide adder is too costly and a few cycles of latency are acceptable.
- Start/busy/done handshake toward the requesting controller.

---
 rtl/nibble_add_seq_if.sv | 25 ++
 rtl/nibble_add_seq.sv | 120 ++++++++++++
 tb/tb_nibble_add_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Start/busy/done handshake bundle for nibble_add_seq.
// The sub field exists only when NIBBLE_ADD_SEQ_SUB_EN is defined.
interface nibble_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit slice per clock, LS nibble first.
// Define NIBBLE_ADD_SEQ_SUB_EN to add a captured sub request (a - b, cout = no borrow).
module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    nibble_add_seq_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NIB-1:0][3:0] r_a;
    logic [NIB-1:0][3:0] r_b;
    logic [NIB-1:0][3:0] r_res;
    logic [NIB-1:0][3:0] r_sum;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_busy;
    logic                r_done;

    logic [WIDTH-1:0]    w_bCapture;
    logic                w_cCapture;
    logic [4:0]          w_add;
    logic [NIB-1:0][3:0] w_resNext;
    logic                w_idxLast;
    logic                w_idxBad;

    // Subtraction is folded into capture: B is stored inverted and the carry seeded with 1.
    always_comb begin
        w_bCapture = bus.b;
        w_cCapture = bus.cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        if (bus.sub) begin
            w_bCapture = ~bus.b;
            w_cCapture = 1'b1;
        end
`endif
    end

    always_comb begin
        w_add            = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]} + {4'd0, r_carry};
        w_resNext        = r_res;
        w_resNext[r_idx] = w_add[3:0];
        w_idxLast        = (r_idx == IW'(NIB - 1));
        w_idxBad         = (int'(r_idx) >= NIB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_bCapture;
                        r_carry <= w_cCapture;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_idxBad) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_res   <= w_resNext;
                        r_carry <= w_add[4];
                        if (w_idxLast) begin
                            r_sum   <= w_resNext;
                            r_cout  <= w_add[4];
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: directed cases plus random operations
// checked against a plain-arithmetic model; sub cases run when NIBBLE_ADD_SEQ_SUB_EN is set.
module tb_nibble_add_seq;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst;

    nibble_add_seq_if #(.WIDTH(WIDTH)) bus ();

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               checkCount = 0;
    int               passCount  = 0;
    logic [WIDTH-1:0] modelSum;
    logic             modelCout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Reference: plain unsigned arithmetic; subtraction reports cout as "no borrow".
    function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
        logic [WIDTH:0] r;
        if (sub) begin
            r[WIDTH-1:0] = a - b;
            r[WIDTH]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input logic holdStart);
        logic [WIDTH:0] expected;
        expected = refModel(a, b, cin, sub);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.sub   = sub;
`endif
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            bus.start = holdStart;
            if (holdStart) begin
                bus.a   = WIDTH'($urandom);
                bus.b   = WIDTH'($urandom);
                bus.cin = 1'($urandom);
            end
            checkOutput($sformatf("busyRun%0d", i), 32'(bus.busy), 32'd1);
            checkOutput($sformatf("doneRun%0d", i), 32'(bus.done), 32'd0);
            checkOutput($sformatf("sumHeld%0d", i), 32'(bus.sum), 32'(modelSum));
        end
        @(negedge clk);
        modelSum  = expected[WIDTH-1:0];
        modelCout = expected[WIDTH];
        checkOutput("donePulse", 32'(bus.done), 32'd1);
        checkOutput("busyDone", 32'(bus.busy), 32'd0);
        checkOutput("sum", 32'(bus.sum), 32'(modelSum));
        checkOutput("cout", 32'(bus.cout), 32'(modelCout));
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("doneCleared", 32'(bus.done), 32'd0);
        checkOutput("busyIdle", 32'(bus.busy), 32'd0);
        checkOutput("sumHeldIdle", 32'(bus.sum), 32'(modelSum));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic             rs;
        logic             rh;

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.sub   = 1'b0;
`endif
        modelSum  = '0;
        modelCout = 1'b0;
        #1 rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start = ~bus.start;
            bus.a     = 16'hFFFF;
            bus.b     = 16'h0001;
            checkOutput("rstBusy", 32'(bus.busy), 32'd0);
            checkOutput("rstDone", 32'(bus.done), 32'd0);
            checkOutput("rstSum", 32'(bus.sum), 32'd0);
            checkOutput("rstCout", 32'(bus.cout), 32'd0);
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;

        $display("[TB] directed adds");
        applyStimulus(16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        $display("[TB] start held during run");
        applyStimulus(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1);

        $display("[TB] abort mid-run");
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.sub   = 1'b0;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("abortBusy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        modelSum  = '0;
        modelCout = 1'b0;
        checkOutput("asyncSum", 32'(bus.sum), 32'd0);
        checkOutput("asyncCout", 32'(bus.cout), 32'd0);
        checkOutput("asyncBusy", 32'(bus.busy), 32'd0);
        checkOutput("asyncDone", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abortNoDone%0d", i), 32'(bus.done), 32'd0);
            checkOutput($sformatf("abortIdle%0d", i), 32'(bus.busy), 32'd0);
        end
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
        $display("[TB] directed subtracts");
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] random operations");
        for (int n = 0; n < 24; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rh = 1'($urandom);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            applyStimulus(ra, rb, rc, rs, rh);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
